// File: rtl/ecies_hash_arbiter.sv
// ecies_hash_arbiter
// Shares one hash core between four ECIES requesters: encrypt hash, decrypt
// hash, encrypt KDF and decrypt KDF. Each requester holds at most one request.
// Pending requests are granted round-robin, one core transaction at a time,
// and every requester keeps its own digest register.

module ecies_hash_arbiter #(
    parameter int message_width = 32,
    parameter int hashed_width  = 512,
    parameter int integer_size  = 64
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        enc_hash_go,
    input  logic                        dec_hash_go,
    input  logic                        enc_kdf_hashGo,
    input  logic                        dec_kdf_hashGo,

    input  logic [message_width-1:0]    enc_messageToProcess,
    input  logic [message_width-1:0]    dec_messageToProcess,
    input  logic [integer_size+15:0]    encrypt_kdf_req,
    input  logic [integer_size+15:0]    decrypt_kdf_req,

    output logic                        enc_hash_done,
    output logic                        dec_hash_done,
    output logic                        enc_kdf_hashDone,
    output logic                        dec_kdf_hashDone,

    output logic [hashed_width-1:0]     enc_hashedMessage,
    output logic [hashed_width-1:0]     dec_hashedMessage,
    output logic [hashed_width-1:0]     encrypt_kdf_hashed,
    output logic [hashed_width-1:0]     decrypt_kdf_hashed,

    output logic                        hash_ready,

    output logic                        core_go,
    output logic [integer_size+15:0]    core_data,
    input  logic                        core_ready,
    input  logic                        core_done,
    input  logic [hashed_width-1:0]     core_out,

    output logic [3:0]                  overrun
);

    localparam int req_width = integer_size + 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [3:0]             go;
    logic [3:0]             pending;
    logic [3:0]             granted_mask;
    logic [3:0]             accept;
    logic [3:0]             reject;

    logic [1:0]             rr_ptr;
    logic [1:0]             grant;
    logic [1:0]             sel_idx;
    logic                   sel_valid;
    logic [1:0]             cand;

    logic [message_width-1:0] msg0;
    logic [message_width-1:0] msg1;
    logic [req_width-1:0]     kdf2;
    logic [req_width-1:0]     kdf3;
    logic [req_width-1:0]     sel_payload;

    logic                   grant_load;
    logic                   core_go_next;
    logic                   digest_load;
    logic [3:0]             done_next;
    logic [3:0]             done_reg;

    assign go = {dec_kdf_hashGo, enc_kdf_hashGo, dec_hash_go, enc_hash_go};

    // The granted requester is busy from ISSUE through RESP, so its go is
    // treated the same as a go arriving while it is already pending.
    assign granted_mask = (state != IDLE) ? (4'b0001 << grant) : 4'b0000;
    assign accept       = go & ~pending & ~granted_mask;
    assign reject       = go & ~accept;

    assign hash_ready = (state == IDLE) && core_ready;

    assign enc_hash_done    = done_reg[0];
    assign dec_hash_done    = done_reg[1];
    assign enc_kdf_hashDone = done_reg[2];
    assign dec_kdf_hashDone = done_reg[3];

    // Round-robin pick: scan from rr_ptr upward; descending loop so the
    // candidate closest to rr_ptr overwrites the others.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = rr_ptr;
        cand      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (pending[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Payload of the selected requester, message words zero-extended.
    always_comb begin
        sel_payload = '0;
        case (sel_idx)
            2'd0:    sel_payload = {{(req_width-message_width){1'b0}}, msg0};
            2'd1:    sel_payload = {{(req_width-message_width){1'b0}}, msg1};
            2'd2:    sel_payload = kdf2;
            default: sel_payload = kdf3;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and the strobes that drive the registered outputs.
    always_comb begin
        state_next   = state;
        grant_load   = 1'b0;
        core_go_next = 1'b0;
        digest_load  = 1'b0;
        done_next    = 4'b0000;
        case (state)
            IDLE: begin
                if (sel_valid && core_ready) begin
                    state_next   = ISSUE;
                    grant_load   = 1'b1;
                    core_go_next = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_next  = RESP;
                    digest_load = 1'b1;
                    done_next   = 4'b0001 << grant;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending bits: set on an accepted go, cleared when the request is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending | accept) & ~(grant_load ? (4'b0001 << sel_idx) : 4'b0000);
        end
    end

    // Sticky flags for go pulses dropped because the requester was busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 4'b0000;
        end else begin
            overrun <= overrun | reject;
        end
    end

    // Payload capture; a dropped go leaves the original payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg0 <= '0;
            msg1 <= '0;
            kdf2 <= '0;
            kdf3 <= '0;
        end else begin
            if (accept[0]) msg0 <= enc_messageToProcess;
            if (accept[1]) msg1 <= dec_messageToProcess;
            if (accept[2]) kdf2 <= encrypt_kdf_req;
            if (accept[3]) kdf3 <= decrypt_kdf_req;
        end
    end

    // Grant record and core request; core_data is held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= 2'd0;
            core_data <= '0;
            core_go   <= 1'b0;
        end else begin
            core_go <= core_go_next;
            if (grant_load) begin
                grant     <= sel_idx;
                core_data <= sel_payload;
            end
        end
    end

    // Round-robin pointer advances past the requester just answered.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (state == RESP) begin
            rr_ptr <= grant + 2'd1;
        end
    end

    // One-cycle done pulses, aligned with the digest update.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg <= 4'b0000;
        end else begin
            done_reg <= done_next;
        end
    end

    // Per-requester digests, written only on that requester's completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_hashedMessage  <= '0;
            dec_hashedMessage  <= '0;
            encrypt_kdf_hashed <= '0;
            decrypt_kdf_hashed <= '0;
        end else if (digest_load) begin
            case (grant)
                2'd0:    enc_hashedMessage  <= core_out;
                2'd1:    dec_hashedMessage  <= core_out;
                2'd2:    encrypt_kdf_hashed <= core_out;
                default: decrypt_kdf_hashed <= core_out;
            endcase
        end
    end

endmodule

// File: tb/tb_ecies_hash_arbiter.sv
// tb_ecies_hash_arbiter
// Directed bench for the four-way hash core arbiter; the bench plays the hash
// core itself and answers each core_go with a chosen digest.

module tb_ecies_hash_arbiter;

    logic          clk;
    logic          rst;
    logic          enc_hash_go;
    logic          dec_hash_go;
    logic          enc_kdf_hashGo;
    logic          dec_kdf_hashGo;
    logic [31:0]   enc_messageToProcess;
    logic [31:0]   dec_messageToProcess;
    logic [79:0]   encrypt_kdf_req;
    logic [79:0]   decrypt_kdf_req;
    logic          enc_hash_done;
    logic          dec_hash_done;
    logic          enc_kdf_hashDone;
    logic          dec_kdf_hashDone;
    logic [511:0]  enc_hashedMessage;
    logic [511:0]  dec_hashedMessage;
    logic [511:0]  encrypt_kdf_hashed;
    logic [511:0]  decrypt_kdf_hashed;
    logic          hash_ready;
    logic          core_go;
    logic [79:0]   core_data;
    logic          core_ready;
    logic          core_done;
    logic [511:0]  core_out;
    logic [3:0]    overrun;

    int checks = 0;
    int errors = 0;

    logic [511:0]  resp_a;
    logic [511:0]  resp_b;
    logic [511:0]  resp_c;
    logic [511:0]  resp_d;

    ecies_hash_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .enc_hash_go          (enc_hash_go),
        .dec_hash_go          (dec_hash_go),
        .enc_kdf_hashGo       (enc_kdf_hashGo),
        .dec_kdf_hashGo       (dec_kdf_hashGo),
        .enc_messageToProcess (enc_messageToProcess),
        .dec_messageToProcess (dec_messageToProcess),
        .encrypt_kdf_req      (encrypt_kdf_req),
        .decrypt_kdf_req      (decrypt_kdf_req),
        .enc_hash_done        (enc_hash_done),
        .dec_hash_done        (dec_hash_done),
        .enc_kdf_hashDone     (enc_kdf_hashDone),
        .dec_kdf_hashDone     (dec_kdf_hashDone),
        .enc_hashedMessage    (enc_hashedMessage),
        .dec_hashedMessage    (dec_hashedMessage),
        .encrypt_kdf_hashed   (encrypt_kdf_hashed),
        .decrypt_kdf_hashed   (decrypt_kdf_hashed),
        .hash_ready           (hash_ready),
        .core_go              (core_go),
        .core_data            (core_data),
        .core_ready           (core_ready),
        .core_done            (core_done),
        .core_out             (core_out),
        .overrun              (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so inputs/outputs are away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] doneVec();
        return {dec_kdf_hashDone, enc_kdf_hashDone, dec_hash_done, enc_hash_done};
    endfunction

    function automatic logic [511:0] digestOf(input int idx);
        case (idx)
            0:       return enc_hashedMessage;
            1:       return dec_hashedMessage;
            2:       return encrypt_kdf_hashed;
            default: return decrypt_kdf_hashed;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] gos);
        enc_hash_go    = gos[0];
        dec_hash_go    = gos[1];
        enc_kdf_hashGo = gos[2];
        dec_kdf_hashGo = gos[3];
        tick();
        enc_hash_go    = 1'b0;
        dec_hash_go    = 1'b0;
        enc_kdf_hashGo = 1'b0;
        dec_kdf_hashGo = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Act as the core for one transaction: wait for core_go, check payload,
    // answer with resp, and check the done pulse and digest of requester idx.
    task automatic serveOne(input string tag, input int idx, input logic [79:0] exp_data, input logic [511:0] resp);
        for (int i = 0; i < 20 && core_go !== 1'b1; i++) tick();
        checkOutput({tag, "_core_go"}, {511'd0, core_go}, 512'd1);
        checkOutput({tag, "_core_data"}, {432'd0, core_data}, {432'd0, exp_data});
        tick();
        checkOutput({tag, "_go_one_cycle"}, {511'd0, core_go}, 512'd0);
        core_out  = resp;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checkOutput({tag, "_done"}, {508'd0, doneVec()}, {508'd0, 4'b0001 << idx});
        checkOutput({tag, "_digest"}, digestOf(idx), resp);
        tick();
        checkOutput({tag, "_done_clear"}, {508'd0, doneVec()}, 512'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        enc_hash_go          = 1'b0;
        dec_hash_go          = 1'b0;
        enc_kdf_hashGo       = 1'b0;
        dec_kdf_hashGo       = 1'b0;
        enc_messageToProcess = '0;
        dec_messageToProcess = '0;
        encrypt_kdf_req      = '0;
        decrypt_kdf_req      = '0;
        core_ready           = 1'b1;
        core_done            = 1'b0;
        core_out             = '0;
        resp_a = {64{8'h5A}};
        resp_b = {64{8'hC3}};
        resp_c = {16{32'h1234_5678}};
        resp_d = {8{64'hDEAD_BEEF_0BAD_F00D}};

        doReset();
        checkOutput("rst_hash_ready", {511'd0, hash_ready}, 512'd1);
        checkOutput("rst_core_go", {511'd0, core_go}, 512'd0);
        checkOutput("rst_core_data", {432'd0, core_data}, 512'd0);
        checkOutput("rst_overrun", {508'd0, overrun}, 512'd0);
        checkOutput("rst_done", {508'd0, doneVec()}, 512'd0);
        checkOutput("rst_digest0", enc_hashedMessage, 512'd0);

        // Single request with exact latency.
        enc_messageToProcess = 32'h0000_ABCD;
        applyStimulus(4'b0001);
        checkOutput("single_no_go_yet", {511'd0, core_go}, 512'd0);
        tick();
        checkOutput("single_go_latency", {511'd0, core_go}, 512'd1);
        checkOutput("single_busy", {511'd0, hash_ready}, 512'd0);
        serveOne("single", 0, 80'h0000_ABCD, resp_a);
        checkOutput("single_idle_ready", {511'd0, hash_ready}, 512'd1);
        checkOutput("single_digest_hold", enc_hashedMessage, resp_a);

        // Four simultaneous requests from rr_ptr=0: order 0,1,2,3.
        doReset();
        enc_messageToProcess = 32'h0000_0100;
        dec_messageToProcess = 32'h0000_0200;
        encrypt_kdf_req      = 80'h3333_0000_0000_0000_0333;
        decrypt_kdf_req      = 80'h4444_0000_0000_0000_0444;
        applyStimulus(4'b1111);
        serveOne("all_r0", 0, 80'h100, resp_a);
        serveOne("all_r1", 1, 80'h200, resp_b);
        serveOne("all_r2", 2, 80'h3333_0000_0000_0000_0333, resp_c);
        serveOne("all_r3", 3, 80'h4444_0000_0000_0000_0444, resp_d);
        checkOutput("all_overrun", {508'd0, overrun}, 512'd0);
        checkOutput("all_hold0", enc_hashedMessage, resp_a);
        checkOutput("all_hold2", encrypt_kdf_hashed, resp_c);

        // Fairness: after requester 1 completes, 3 wins over 0; a go for 1
        // during the active grant is captured and served after 0.
        dec_messageToProcess = 32'h0000_1234;
        applyStimulus(4'b0010);
        serveOne("fair_r1", 1, 80'h1234, resp_c);
        enc_messageToProcess = 32'h0000_0A0A;
        decrypt_kdf_req      = 80'h0000_0000_0000_0000_0B0B;
        applyStimulus(4'b1001);
        dec_messageToProcess = 32'h0000_0C0C;
        applyStimulus(4'b0010);
        serveOne("fair_r3", 3, 80'h0B0B, resp_a);
        serveOne("fair_r0", 0, 80'h0A0A, resp_b);
        serveOne("fair_r1b", 1, 80'h0C0C, resp_d);
        checkOutput("fair_overrun", {508'd0, overrun}, 512'd0);

        // Overrun: second go before grant is dropped, first payload kept.
        core_ready = 1'b0;
        encrypt_kdf_req = 80'h11;
        applyStimulus(4'b0100);
        encrypt_kdf_req = 80'h22;
        applyStimulus(4'b0100);
        tick();
        checkOutput("ovr_flag", {508'd0, overrun}, 512'h4);
        checkOutput("ovr_not_ready", {511'd0, hash_ready}, 512'd0);
        checkOutput("ovr_held_no_go", {511'd0, core_go}, 512'd0);
        core_ready = 1'b1;
        serveOne("ovr", 2, 80'h11, resp_d);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ovr_no_second_go", {511'd0, core_go}, 512'd0);
        checkOutput("ovr_no_second_done", {508'd0, doneVec()}, 512'd0);

        // Reset during WAIT; the late core_done must be ignored.
        enc_messageToProcess = 32'h77;
        applyStimulus(4'b0001);
        for (int i = 0; i < 20 && core_go !== 1'b1; i++) tick();
        checkOutput("rstw_core_go", {511'd0, core_go}, 512'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        core_out  = {512{1'b1}};
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checkOutput("rstw_done", {508'd0, doneVec()}, 512'd0);
        checkOutput("rstw_digest0", enc_hashedMessage, 512'd0);
        checkOutput("rstw_digest3", decrypt_kdf_hashed, 512'd0);
        checkOutput("rstw_overrun", {508'd0, overrun}, 512'd0);
        checkOutput("rstw_core_data", {432'd0, core_data}, 512'd0);
        checkOutput("rstw_ready_hi", {511'd0, hash_ready}, 512'd1);
        tick();
        checkOutput("rstw_done_later", {508'd0, doneVec()}, 512'd0);
        core_ready = 1'b0;
        #1;
        checkOutput("rstw_ready_lo", {511'd0, hash_ready}, 512'd0);
        core_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecies_hash_arbiter.md
ECIES_HASH_ARBITER -- requirements
Module: ecies_hash_arbiter

Interface
REQ-001 SHALL have parameters: message_width, default 32, ECIES message word width; hashed_width, default 512, hash digest width; integer_size, default 64, EC integer width (KDF request is integer_size+16 wide).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports enc_hash_go / dec_hash_go / enc_kdf_hashGo / dec_kdf_hashGo, input, 1 each, request pulses from the ECIES top (requesters 0..3).
REQ-005 SHALL have ports enc_messageToProcess / dec_messageToProcess, input, message_width, hash payload for requesters 0 and 1.
REQ-006 SHALL have ports encrypt_kdf_req / decrypt_kdf_req, input, integer_size+16, KDF payload for requesters 2 and 3.
REQ-007 SHALL have ports enc_hash_done / dec_hash_done / enc_kdf_hashDone / dec_kdf_hashDone, output, 1 each, one-cycle completion pulses.
REQ-008 SHALL have ports enc_hashedMessage / dec_hashedMessage / encrypt_kdf_hashed / decrypt_kdf_hashed, output, hashed_width each, registered per-requester digests.
REQ-009 SHALL have port hash_ready, output, 1, high when the arbiter is in IDLE and core_ready is high.
REQ-010 SHALL have ports core_go (output, 1), core_data (output, integer_size+16), core_ready (input, 1), core_done (input, 1), core_out (input, hashed_width), the shared hash core handshake.
REQ-011 SHALL have port overrun, output, 4, sticky per-requester dropped-request flags.

Function
REQ-012 SHALL latch a requester's payload and set its pending bit on the rising edge where its go is high and its pending bit is clear.
REQ-013 SHALL ignore go while that requester is pending or granted, keep the original payload, and set the corresponding overrun bit.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: when any pending bit is set and core_ready=1, SHALL select a requester round-robin starting at rr_ptr, clear its pending bit, record the grant, and go to ISSUE.
REQ-016 ISSUE: SHALL assert core_go for exactly one cycle, drive core_data with the granted payload, and go to WAIT.
REQ-017 core_data SHALL carry message payloads zero-extended in the MSBs to integer_size+16 bits, and KDF payloads unchanged; it SHALL hold that value from ISSUE through WAIT.
REQ-018 WAIT: on core_done=1, SHALL load core_out into the granted requester's digest register and go to RESP; core_done in any other state SHALL be ignored.
REQ-019 RESP: SHALL pulse the granted requester's done output for exactly one cycle, set rr_ptr to grant+1 mod 4, and return to IDLE.
REQ-020 Minimum latency SHALL be: go at edge t → core_go high in cycle t+2; core_done at edge d → digest valid and done high in cycle d+1.
REQ-021 Digest registers SHALL hold their value until the same requester's next completion.
REQ-022 A go arriving for a requester other than the granted one, in any state, SHALL be captured per REQ-012 without disturbing the active transaction.
REQ-023 When core_ready=0 in IDLE, the FSM SHALL remain in IDLE and pending requests SHALL be retained.

Reset
REQ-024 While rst=1 on a clock edge, SHALL set FSM=IDLE, rr_ptr=0, pending=0, overrun=0, all done outputs=0, core_go=0, core_data=0, and all digest registers=0, including when reset occurs mid-transaction.
REQ-025 A core_done arriving after a reset SHALL be ignored per REQ-018.

Verification
REQ-026 Single request: core_ready=1, enc_hash_go pulse with message 0x0000ABCD → core_go one cycle later, core_data=0x...0000ABCD; core_out=512'h5A...5A → enc_hashedMessage=5A..5A and enc_hash_done pulses once.
REQ-027 Simultaneous requests: all four go pulses on the same edge → grant order 0,1,2,3; each done pulses once in that order; overrun=0.
REQ-028 Fairness: rr_ptr=2 after a requester-1 completion, requesters 0 and 3 pending → requester 3 is granted before requester 0.
REQ-029 Overrun: enc_kdf_hashGo pulsed twice before its grant, with payloads 0x11 and 0x22 → core_data=0x11, overrun[2]=1, one done pulse only.
REQ-030 Reset mid-WAIT: rst during WAIT, followed by core_done → no done pulse, digests=0, FSM IDLE, hash_ready follows core_ready.
